// File: rtl/imm_pkg.sv
// Shared definitions for the immediate field decoder:
// MIPS opcodes, FSM encoding and word geometry.
package imm_pkg;

   localparam int NIBBLES = 8;

   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      DECODE  = 2'd1,
      HOLD    = 2'd2
   } state_e;

endpackage

// File: rtl/imm_class_decode.sv
// Opcode classifier: sign-extend, zero-extend or no immediate.
// Purely combinational; the caller registers the result.
module imm_class_decode
   import imm_pkg::*;
(
   input  logic [5:0] opcode,
   output logic       sext,
   output logic       no_imm
);

   always_comb begin
      sext   = 1'b0;
      no_imm = 1'b0;
      unique case (opcode)
         OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
         OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
            sext = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            sext = 1'b0;
         end
         default: begin
            no_imm = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_field_decoder.sv
// Assembles a 32-bit instruction from switch nibbles, extracts the
// 16-bit immediate and offers it downstream via valid/ready.
module imm_field_decoder #(
   parameter int NIBBLES = imm_pkg::NIBBLES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  nib_in,
   input  logic        nib_valid,
   output logic        nib_ready,
   output logic [2:0]  nib_count,
   input  logic        flush,
   output logic [31:0] instr_out,
   output logic [15:0] imm_out,
   output logic        sext_out,
   output logic        no_imm,
   output logic        imm_valid,
   input  logic        imm_ready
);

   import imm_pkg::*;

   localparam logic [2:0] LAST = 3'(NIBBLES - 1);

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] instr_q, instr_d;
   logic [15:0] imm_q, imm_d;
   logic        sext_q, sext_d;
   logic        noimm_q, noimm_d;
   logic        cls_sext, cls_noimm;

   imm_class_decode u_cls (
      .opcode (instr_q[31:26]),
      .sext   (cls_sext),
      .no_imm (cls_noimm)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      instr_d = instr_q;
      imm_d   = imm_q;
      sext_d  = sext_q;
      noimm_d = noimm_q;
      if (flush) begin
         state_d = COLLECT;
         cnt_d   = 3'd0;
         instr_d = 32'd0;
      end else begin
         unique case (state_q)
            COLLECT: begin
               if (nib_valid) begin
                  instr_d[{cnt_q, 2'b00} +: 4] = nib_in;
                  if (cnt_q == LAST) begin
                     cnt_d   = 3'd0;
                     state_d = DECODE;
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end
            end
            DECODE: begin
               imm_d   = cls_noimm ? 16'd0 : instr_q[15:0];
               sext_d  = cls_sext & ~cls_noimm;
               noimm_d = cls_noimm;
               state_d = HOLD;
            end
            HOLD: begin
               if (imm_ready) state_d = COLLECT;
            end
            default: state_d = COLLECT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= COLLECT;
         cnt_q   <= 3'd0;
         instr_q <= 32'd0;
         imm_q   <= 16'd0;
         sext_q  <= 1'b0;
         noimm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         instr_q <= instr_d;
         imm_q   <= imm_d;
         sext_q  <= sext_d;
         noimm_q <= noimm_d;
      end
   end

   assign nib_ready = (state_q == COLLECT);
   assign imm_valid = (state_q == HOLD);
   assign nib_count = cnt_q;
   assign instr_out = instr_q;
   assign imm_out   = imm_q;
   assign sext_out  = sext_q;
   assign no_imm    = noimm_q;

endmodule

// File: tb/tb_imm_field_decoder.sv
// Directed bench for imm_field_decoder: load words nibble by nibble
// and compare against hand-computed immediates and classes.
module tb_imm_field_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  nib_in;
   logic        nib_valid;
   logic        nib_ready;
   logic [2:0]  nib_count;
   logic        flush;
   logic [31:0] instr_out;
   logic [15:0] imm_out;
   logic        sext_out;
   logic        no_imm;
   logic        imm_valid;
   logic        imm_ready;

   int n_chk  = 0;
   int n_fail = 0;

   imm_field_decoder dut (
      .clk       (clk),
      .rst       (rst),
      .nib_in    (nib_in),
      .nib_valid (nib_valid),
      .nib_ready (nib_ready),
      .nib_count (nib_count),
      .flush     (flush),
      .instr_out (instr_out),
      .imm_out   (imm_out),
      .sext_out  (sext_out),
      .no_imm    (no_imm),
      .imm_valid (imm_valid),
      .imm_ready (imm_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Drives 8 back-to-back nibbles; returns at the negedge of the
   // DECODE cycle. With extra set, nib_valid stays high in DECODE.
   task automatic load(input logic [31:0] w, input bit extra);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         nib_in    = w[4*k +: 4];
         nib_valid = 1'b1;
      end
      @(negedge clk);
      if (extra) nib_in = 4'h7;
      else nib_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!imm_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!imm_valid) check("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic word(input string tag, input logic [31:0] w,
                       input logic [15:0] imm, input logic sx,
                       input logic ni);
      load(w, 1'b0);
      wait_valid();
      check({tag, "_imm"}, 32'(imm_out), 32'(imm));
      check({tag, "_sext"}, 32'(sext_out), 32'(sx));
      check({tag, "_noimm"}, 32'(no_imm), 32'(ni));
      check({tag, "_instr"}, instr_out, w);
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      nib_in    = 4'h0;
      nib_valid = 1'b0;
      flush     = 1'b0;
      imm_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(nib_ready), 32'd1);
      check("rst_valid", 32'(imm_valid), 32'd0);
      check("rst_count", 32'(nib_count), 32'd0);
      check("rst_instr", instr_out, 32'd0);
      check("rst_imm", 32'(imm_out), 32'd0);

      // addi: latency, DECODE drop of nib_valid, retention after accept
      load(32'h2008FFFC, 1'b1);
      check("addi_dec_valid", 32'(imm_valid), 32'd0);
      check("addi_dec_ready", 32'(nib_ready), 32'd0);
      @(negedge clk);
      nib_valid = 1'b0;
      check("addi_valid", 32'(imm_valid), 32'd1);
      check("addi_imm", 32'(imm_out), 32'hFFFC);
      check("addi_sext", 32'(sext_out), 32'd1);
      check("addi_noimm", 32'(no_imm), 32'd0);
      check("addi_instr", instr_out, 32'h2008FFFC);
      check("addi_count", 32'(nib_count), 32'd0);
      @(negedge clk);
      check("addi_acc_valid", 32'(imm_valid), 32'd0);
      check("addi_acc_ready", 32'(nib_ready), 32'd1);
      check("addi_keep_imm", 32'(imm_out), 32'hFFFC);

      word("ori", 32'h35088000, 16'h8000, 1'b0, 1'b0);
      word("rtype", 32'h01095020, 16'h0000, 1'b0, 1'b1);
      word("lui", 32'h3C01ABCD, 16'hABCD, 1'b0, 1'b0);
      word("jump", 32'h08000010, 16'h0000, 1'b0, 1'b1);
      word("sw", 32'hAFBF0018, 16'h0018, 1'b1, 1'b0);

      // backpressure with nibble strobes during HOLD
      imm_ready = 1'b0;
      load(32'h24081234, 1'b0);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         nib_in    = 4'hA;
         nib_valid = 1'b1;
         @(negedge clk);
         check("bp_valid", 32'(imm_valid), 32'd1);
         check("bp_imm", 32'(imm_out), 32'h1234);
         check("bp_count", 32'(nib_count), 32'd0);
         check("bp_instr", instr_out, 32'h24081234);
      end
      nib_valid = 1'b0;
      imm_ready = 1'b1;
      @(negedge clk);
      check("bp_drop", 32'(imm_valid), 32'd0);
      check("bp_sext", 32'(sext_out), 32'd1);

      // flush mid-load
      for (int k = 0; k < 3; k++) begin
         nib_in    = 4'hF;
         nib_valid = 1'b1;
         @(negedge clk);
      end
      nib_valid = 1'b0;
      check("fl_count3", 32'(nib_count), 32'd3);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("fl_count", 32'(nib_count), 32'd0);
      check("fl_instr", instr_out, 32'd0);
      check("fl_keep_imm", 32'(imm_out), 32'h1234);
      word("lw", 32'h8C430004, 16'h0004, 1'b1, 1'b0);

      // reset while a word is held
      imm_ready = 1'b0;
      load(32'h2008FFFC, 1'b0);
      wait_valid();
      rst = 1'b1;
      @(negedge clk);
      check("rh_valid", 32'(imm_valid), 32'd0);
      check("rh_ready", 32'(nib_ready), 32'd1);
      check("rh_instr", instr_out, 32'd0);
      check("rh_imm", 32'(imm_out), 32'd0);
      check("rh_sext", 32'(sext_out), 32'd0);
      check("rh_noimm", 32'(no_imm), 32'd0);
      check("rh_count", 32'(nib_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_field_decoder.md
# imm_field_decoder

Upstream stage of the immediate extender on the extension board. Collects a 32-bit MIPS instruction entered four bits at a time from the board switches. Slices out the 16-bit immediate and classifies the opcode to decide sign- vs zero-extension. Presents `imm_out` and `sext_out` to the extender through a valid/ready handshake.

## Interface
Parameters:
- NIBBLES, 8, nibbles per instruction word (fixed at 8 for 32-bit).

Ports:
- `clk`  in  1  board clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `nib_in`  in  4  instruction nibble.
- `nib_valid`  in  1  one-cycle strobe (debounced upstream); `nib_in` valid this cycle.
- `nib_ready`  out  1  high only in COLLECT; nibble accepted when `nib_valid && nib_ready`.
- `nib_count`  out  3  index of next nibble slot (0..7), drives the board digit select.
- `flush`  in  1  synchronous abort; discards the partial or held word.
- `instr_out`  out  32  assembled instruction, for display.
- `imm_out`  out  16  `instr[15:0]` (0 when `no_imm`).
- `sext_out`  out  1  1 = sign-extend, 0 = zero-extend.
- `no_imm`  out  1  opcode carries no immediate (R-type, J, JAL, unknown).
- `imm_valid`  out  1  result valid; held until accepted.
- `imm_ready`  in  1  downstream extender accepts.

## Operation
- States: COLLECT, DECODE, HOLD.
- **COLLECT**
  - On each accepted nibble, write `instr[4*k+3:4*k] = nib_in`, where k = `nib_count`, least-significant nibble first.
  - `nib_count` increments. When k = 7 is accepted, `nib_count` wraps to 0 and the state goes to DECODE.
- **DECODE** (exactly one cycle)
  - Register `imm_out`, `sext_out` and `no_imm` from `instr[31:26]`.
  - Sign-extend set: 0x04 beq, 0x05 bne, 0x08 addi, 0x09 addiu, 0x0A slti, 0x0B sltiu, 0x23 lw, 0x2B sw.
  - Zero-extend set: 0x0C andi, 0x0D ori, 0x0E xori, 0x0F lui.
  - Any other opcode: `no_imm=1`, `imm_out=0`, `sext_out=0`.
  - Go to HOLD.
- **HOLD**
  - `imm_valid=1`. `imm_out`, `sext_out`, `no_imm` and `instr_out` are stable.
  - On `imm_valid && imm_ready`, go to COLLECT.
- `nib_valid` outside COLLECT is ignored: no write, no count change.
- After a handshake, `imm_out`, `sext_out`, `no_imm` and `instr_out` retain their values until the next DECODE; only `imm_valid` drops.
- **flush**
  - From any state: go to COLLECT, `nib_count=0`, `imm_valid=0`.
  - The partial `instr` is cleared to 0; other outputs are unchanged.
  - `flush` has priority over `nib_valid` and the handshake.
- `rst` has priority over everything.

## Timing
- Reset values: state COLLECT, `nib_count=0`, `instr_out=0`, `imm_out=0`, `sext_out=0`, `no_imm=0`, `imm_valid=0`.
- `nib_ready=1` is combinational from state, so it is 1 in the cycle after reset.
- Latency: the 8th nibble is accepted at edge N, DECODE runs in cycle N+1, and `imm_valid` rises after edge N+1, so it is high in cycle N+2.
- Handshake:
  - Accepted at edge M, so `imm_valid=0` and `nib_ready=1` in cycle M+1.
  - Minimum HOLD is one cycle when `imm_ready` is already high.
- Nibbles cannot overlap a held word. Throughput is at most one word per 10 cycles.
- `nib_valid` on the same edge as the wrap into DECODE is the 8th nibble itself. A `nib_valid` in DECODE is dropped.
- Reset or flush during HOLD drops `imm_valid` in the next cycle; the held word is lost and not re-presented.

## Structure
- Shared package `imm_pkg`:
  - opcode localparams (OP_BEQ … OP_LUI);
  - state encoding (COLLECT=2'd0, DECODE=2'd1, HOLD=2'd2);
  - NIBBLES.
- Sub-module `imm_class_decode`: combinational, `opcode[5:0]` → {`sext`, `no_imm`}. The top registers its outputs in DECODE.
- Top holds the FSM, nibble counter, instruction register and output registers.

## Test plan
- **addi sign-extend.** Stimulus: nibbles C,F,F,F,8,0,0,2 (0x2008FFFC) with `imm_ready=1`. Required: `imm_valid` two cycles after the last nibble, `imm_out=0xFFFC`, `sext_out=1`, `no_imm=0`, `instr_out=0x2008FFFC`.
- **ori zero-extend.** Stimulus: 0x35088000. Required: `imm_out=0x8000`, `sext_out=0`.
- **R-type.** Stimulus: 0x01095020. Required: `no_imm=1`, `imm_out=0`, `sext_out=0`.
- **Backpressure.** Stimulus: hold `imm_ready=0` for 5 cycles in HOLD, pulsing `nib_valid` each cycle. Required: outputs stable, `nib_count` stays 0, `imm_valid` drops one cycle after `imm_ready` rises.
- **Flush mid-load.** Stimulus: 3 nibbles, then `flush`, then a full 0x8C430004. Required: `imm_out=0x0004`, `sext_out=1`, with no residue from the partial word.
- **Reset mid-HOLD.** Stimulus: `rst` while `imm_valid=1`. Required: next cycle all outputs at reset values and `nib_ready=1`.
